// File: rtl/ltc2333_acq_driver_if.sv
// LTC2333 conversion/serial-clock pin bundle: the driver owns cnv, scki and sdi;
// the readout stage observes them.
interface ltc2333_acq_driver_if;
    logic cnv;
    logic scki;
    logic sdi;

    modport master (output cnv, output scki, output sdi);
    modport slave  (input  cnv, input  scki, input  sdi);
endinterface

// File: rtl/ltc2333_acq_driver.sv
// LTC2333 acquisition frame driver: cnv pulse, conversion wait, N_SCK scki periods
// with the SoftSpan/channel word on sdi, then a quiet gap. Internal or external trigger.
//
// state   | meaning
// S_IDLE  | waiting for an accepted trigger, all pins low
// S_CNV   | cnv high for CNV_HIGH_CYCLES
// S_CONV  | conversion wait, pins low, CONV_CYCLES
// S_SHIFT | scki toggling every SCK_HALF, control word on sdi
// S_QUIET | QUIET_CYCLES gap, frame_done on the last cycle
module ltc2333_acq_driver #(
    parameter int CNV_HIGH_CYCLES = 4,
    parameter int CONV_CYCLES     = 50,
    parameter int SCK_HALF        = 2,
    parameter int N_SCK           = 12,
    parameter int QUIET_CYCLES    = 4,
    parameter int OVR_W           = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 ext_trig_sel,
    input  logic                 timetrig,
    input  logic [31:0]          period,
    input  logic [3:0]           num_ch,
    input  logic [63:0]          ctrl_words,
    ltc2333_acq_driver_if.master adc,
    output logic                 busy,
    output logic                 frame_done,
    output logic [2:0]           chan_idx,
    output logic [OVR_W-1:0]     overrun_cnt
);

    localparam int TW = $clog2(CNV_HIGH_CYCLES + CONV_CYCLES + SCK_HALF + QUIET_CYCLES + 1);
    localparam int EW = $clog2(2 * N_SCK + 1);

    typedef enum logic [2:0] {S_IDLE, S_CNV, S_CONV, S_SHIFT, S_QUIET} state_t;

    state_t         state, state_nxt;
    logic [TW-1:0]  tmr, tmr_nxt;
    logic [EW-1:0]  tog_cnt, tog_nxt;
    logic           scki_r, scki_nxt;
    logic [7:0]     sh, sh_nxt;
    logic [3:0]     n_eff, n_eff_q;
    logic [31:0]    pcnt;
    logic           timetrig_q, trig_r, enable_q;
    logic           int_trig, trig_comb, tmr_zero, accept, chan_wrap;

    assign tmr_zero  = (tmr == '0);
    assign int_trig  = enable && !ext_trig_sel && (period != 32'd0) && (pcnt == period - 32'd1);
    assign trig_comb = ext_trig_sel ? (timetrig && !timetrig_q) : int_trig;
    assign n_eff     = (num_ch == 4'd0) ? 4'd1 : ((num_ch > 4'd8) ? 4'd8 : num_ch);
    assign chan_wrap = (({1'b0, chan_idx} + 4'd1) >= n_eff_q);

    assign busy       = (state != S_IDLE);
    assign frame_done = (state == S_QUIET) && tmr_zero;
    assign adc.cnv    = (state == S_CNV);
    assign adc.scki   = scki_r;
    assign adc.sdi    = (state == S_SHIFT) && sh[7];

    always_comb begin
        state_nxt = state;
        tmr_nxt   = tmr;
        tog_nxt   = tog_cnt;
        scki_nxt  = scki_r;
        sh_nxt    = sh;
        accept    = 1'b0;
        case (state)
            S_IDLE: begin
                if (trig_r && enable) begin
                    accept    = 1'b1;
                    state_nxt = S_CNV;
                    tmr_nxt   = TW'(CNV_HIGH_CYCLES - 1);
                    sh_nxt    = ctrl_words[{chan_idx, 3'b000} +: 8];
                end
            end
            S_CNV: begin
                if (tmr_zero) begin
                    state_nxt = S_CONV;
                    tmr_nxt   = TW'(CONV_CYCLES - 1);
                end else begin
                    tmr_nxt = tmr - 1'b1;
                end
            end
            S_CONV: begin
                if (tmr_zero) begin
                    state_nxt = S_SHIFT;
                    tmr_nxt   = TW'(SCK_HALF - 1);
                    tog_nxt   = '0;
                    scki_nxt  = 1'b0;
                end else begin
                    tmr_nxt = tmr - 1'b1;
                end
            end
            S_SHIFT: begin
                if (tmr_zero) begin
                    scki_nxt = ~scki_r;
                    tmr_nxt  = TW'(SCK_HALF - 1);
                    // falling scki edge moves sdi to the next lower bit
                    if (scki_r) sh_nxt = {sh[6:0], 1'b0};
                    if (tog_cnt == EW'(2 * N_SCK - 1)) begin
                        state_nxt = S_QUIET;
                        tmr_nxt   = TW'(QUIET_CYCLES - 1);
                    end else begin
                        tog_nxt = tog_cnt + 1'b1;
                    end
                end else begin
                    tmr_nxt = tmr - 1'b1;
                end
            end
            S_QUIET: begin
                if (tmr_zero) state_nxt = S_IDLE;
                else          tmr_nxt   = tmr - 1'b1;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            tmr         <= '0;
            tog_cnt     <= '0;
            scki_r      <= 1'b0;
            sh          <= '0;
            n_eff_q     <= '0;
            pcnt        <= '0;
            timetrig_q  <= 1'b0;
            trig_r      <= 1'b0;
            enable_q    <= 1'b0;
            chan_idx    <= '0;
            overrun_cnt <= '0;
        end else begin
            state      <= state_nxt;
            tmr        <= tmr_nxt;
            tog_cnt    <= tog_nxt;
            scki_r     <= scki_nxt;
            sh         <= sh_nxt;
            timetrig_q <= timetrig;
            trig_r     <= trig_comb;
            enable_q   <= enable;

            if (accept) n_eff_q <= n_eff;

            if (!enable || ext_trig_sel || period == 32'd0 || pcnt == period - 32'd1)
                pcnt <= '0;
            else
                pcnt <= pcnt + 32'd1;

            if (enable && !enable_q)
                chan_idx <= '0;
            else if (frame_done)
                chan_idx <= chan_wrap ? 3'd0 : chan_idx + 3'd1;

            // busy includes the frame_done cycle, so a coincident trigger is dropped
            if (trig_r && enable && busy && !(&overrun_cnt))
                overrun_cnt <= overrun_cnt + OVR_W'(1);
        end
    end

endmodule

// File: tb/tb_ltc2333_acq_driver.sv
// Scoreboard bench for ltc2333_acq_driver: expected frames are queued when triggers
// are driven and compared when the frame's busy window closes.
module tb_ltc2333_acq_driver;

    localparam int FRAME_LEN = 106;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        ext_trig_sel = 1'b1;
    logic        timetrig = 1'b0;
    logic [31:0] period = '0;
    logic [3:0]  num_ch = 4'd1;
    logic [63:0] ctrl_words = 64'h8877_6655_3C0F_C3A5;
    logic        busy, frame_done;
    logic [2:0]  chan_idx;
    logic [15:0] overrun_cnt;

    ltc2333_acq_driver_if adc_if ();

    ltc2333_acq_driver dut (
        .clk(clk), .reset(reset), .enable(enable), .ext_trig_sel(ext_trig_sel),
        .timetrig(timetrig), .period(period), .num_ch(num_ch), .ctrl_words(ctrl_words),
        .adc(adc_if), .busy(busy), .frame_done(frame_done), .chan_idx(chan_idx),
        .overrun_cnt(overrun_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         chan;
        logic [11:0] bits;
        int         gap;
        int         start;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   m_chan = 0;
    int   exp_cnv_rises = 0;
    int   cnv_rises = 0;
    int   aborted = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // monitor: per-frame measurements, sampled on the falling edge
    logic        p_cnv = 0, p_scki = 0, p_busy = 0;
    int          f_start = 0, prev_start = 0, f_chan = 0, f_busy = 0, f_cnv = 0;
    int          f_rise = 0, f_first = 0, f_done = 0;
    logic [11:0] f_bits = '0;

    always @(negedge clk) begin
        exp_t e;
        if (adc_if.cnv === 1'b1 && !p_cnv) begin
            prev_start = f_start;
            f_start = cyc; f_chan = chan_idx; f_busy = 0; f_cnv = 0;
            f_rise = 0; f_first = 0; f_done = 0; f_bits = '0;
            cnv_rises++;
        end
        if (busy === 1'b1) begin
            f_busy++;
            if (adc_if.cnv === 1'b1) f_cnv++;
            if (adc_if.scki === 1'b1 && !p_scki) begin
                f_rise++;
                f_bits = {f_bits[10:0], adc_if.sdi};
                if (f_rise == 1) f_first = cyc;
            end
            if (frame_done === 1'b1) f_done++;
        end
        if (busy !== 1'b1 && p_busy) begin
            if (f_done == 0) aborted++;
            else begin
                chk("frame_expected", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("chan", f_chan, e.chan);
                    chk("sdi_bits", f_bits, e.bits);
                    chk("busy_len", f_busy, FRAME_LEN);
                    chk("cnv_len", f_cnv, 4);
                    chk("scki_rises", f_rise, 12);
                    chk("first_rise", f_first - f_start, 56);
                    chk("done_cnt", f_done, 1);
                    if (e.gap >= 0)   chk("gap", f_start - prev_start, e.gap);
                    if (e.start >= 0) chk("start", f_start, e.start);
                end
            end
        end
        p_cnv  = (adc_if.cnv === 1'b1);
        p_scki = (adc_if.scki === 1'b1);
        p_busy = (busy === 1'b1);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic int eff_n(input logic [3:0] n);
        if (n == 0) return 1;
        if (n > 8) return 8;
        return int'(n);
    endfunction

    task automatic push_frame(input int gap, input int start);
        exp_t e;
        logic [7:0] w;
        w = ctrl_words[m_chan*8 +: 8];
        e.chan = m_chan; e.bits = {w, 4'b0000}; e.gap = gap; e.start = start;
        sb.push_back(e);
        exp_cnv_rises++;
        m_chan = (m_chan + 1 >= eff_n(num_ch)) ? 0 : m_chan + 1;
    endtask

    task automatic pulse_trig();
        timetrig = 1'b1;
        tick(1);
        timetrig = 1'b0;
    endtask

    task automatic wait_sb(input int maxc, input string tag);
        int n = 0;
        while (sb.size() != 0 && n < maxc) begin
            tick(1);
            n++;
        end
        chk(tag, sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        // reset state
        tick(3);
        chk("rst_cnv", adc_if.cnv, 0);
        chk("rst_scki", adc_if.scki, 0);
        chk("rst_sdi", adc_if.sdi, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_chan", chan_idx, 0);
        chk("rst_ovr", overrun_cnt, 0);
        reset = 1'b0;

        // single external trigger, four-channel sequence
        num_ch = 4'd4;
        enable = 1'b1;
        m_chan = 0;
        tick(2);
        push_frame(-1, cyc + 2);
        pulse_trig();
        wait_sb(300, "s1_complete");
        chk("s1_chan_after", chan_idx, 1);

        // enable edge clears the sequence; one-channel frames, word latched at accept
        enable = 1'b0;
        tick(1);
        enable = 1'b1;
        tick(1);
        m_chan = 0;
        chk("s2_chan_clr", chan_idx, 0);
        num_ch = 4'd1;
        push_frame(-1, cyc + 2);
        pulse_trig();
        tick(60);
        ctrl_words[7:0] = 8'hFF;
        num_ch = 4'd0;
        wait_sb(300, "s2_complete_a");
        chk("s2_chan_a", chan_idx, 0);
        push_frame(-1, cyc + 2);
        pulse_trig();
        wait_sb(300, "s2_complete_b");
        chk("s2_chan_b", chan_idx, 0);

        // internal period 200, three channels, 10 frames
        enable = 1'b0;
        ext_trig_sel = 1'b0;
        period = 32'd200;
        num_ch = 4'd3;
        tick(2);
        m_chan = 0;
        for (int i = 0; i < 10; i++) push_frame(i == 0 ? -1 : 200, -1);
        enable = 1'b1;
        wait_sb(2600, "s3_complete");
        enable = 1'b0;
        tick(2);
        chk("s3_ovr", overrun_cnt, 0);

        // period 50 is shorter than a frame: every third trigger accepted
        period = 32'd50;
        tick(1);
        m_chan = 0;
        for (int i = 0; i < 5; i++) push_frame(i == 0 ? -1 : 150, -1);
        enable = 1'b1;
        wait_sb(1000, "s4_complete");
        enable = 1'b0;
        tick(2);
        chk("s4_ovr", overrun_cnt, 10);

        // reset while shifting aborts the frame
        ext_trig_sel = 1'b1;
        enable = 1'b1;
        tick(1);
        m_chan = 0;
        pulse_trig();
        exp_cnv_rises++;
        begin
            int n = 0;
            while (adc_if.scki !== 1'b1 && n < 200) begin
                tick(1);
                n++;
            end
        end
        chk("s5_in_shift", adc_if.scki, 1);
        reset = 1'b1;
        tick(1);
        chk("s5_cnv", adc_if.cnv, 0);
        chk("s5_scki", adc_if.scki, 0);
        chk("s5_sdi", adc_if.sdi, 0);
        chk("s5_busy", busy, 0);
        chk("s5_chan", chan_idx, 0);
        chk("s5_ovr", overrun_cnt, 0);
        reset = 1'b0;
        tick(2);
        chk("s5_aborted", aborted, 1);
        push_frame(-1, cyc + 2);
        pulse_trig();
        wait_sb(300, "s5_complete");

        // enable dropped during conversion: frame finishes, later triggers ignored
        push_frame(-1, cyc + 2);
        pulse_trig();
        tick(15);
        enable = 1'b0;
        wait_sb(300, "s6_complete");
        chk("s6_chan", chan_idx, m_chan);
        tick(5);
        pulse_trig();
        tick(20);
        pulse_trig();
        tick(250);
        chk("s6_cnv_rises", cnv_rises, exp_cnv_rises);
        chk("s6_busy", busy, 0);
        chk("s6_ovr", overrun_cnt, 0);
        chk("s6_aborted", aborted, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ltc2333_acq_driver.md
Name: ltc2333_acq_driver

Overview:
Drives the LTC2333 ADC's conversion and serial-clock pins (cnv, scki, sdi). Its cnv and the ADC's scko echo feed the existing LTC2333 readout and deserializer stage. Each trigger runs one acquisition frame: a cnv pulse, a fixed conversion wait, then 12 scki periods (24 DDR bits) while an 8-bit SoftSpan/channel control word is shifted out on sdi. Frames are triggered by an internal period counter or by the external timetrig, and the block cycles through a programmable channel sequence.

Parameters:
CNV_HIGH_CYCLES, 4, cnv high time in clk cycles (min 1)
CONV_CYCLES, 50, cnv-low wait for conversion before the first scki edge (min 1)
SCK_HALF, 2, scki half-period in clk cycles (min 1)
N_SCK, 12, scki periods per frame (24 DDR bits)
QUIET_CYCLES, 4, idle gap after the last scki falling edge (min 1)
OVR_W, 16, overrun counter width

Ports:
clk  in  1  clock
reset  in  1  synchronous reset, active-high
enable  in  1  allow new frames
ext_trig_sel  in  1  1 = timetrig rising edge triggers; 0 = internal period
timetrig  in  1  external trigger, clk-synchronous
period  in  32  internal trigger period in clk cycles; 0 = no internal triggers
num_ch  in  4  sequence length; 0 treated as 1, >8 clamped to 8
ctrl_words  in  64  8 control words; word i = bits [8i+7:8i]
cnv  out  1  ADC convert start
scki  out  1  ADC serial clock
sdi  out  1  ADC control-word serial data
busy  out  1  frame in progress
frame_done  out  1  one-cycle pulse at end of frame
chan_idx  out  3  sequence index of the current/next frame
overrun_cnt  out  OVR_W  dropped triggers, saturating

Behaviour:
- Reset: all outputs go to 0 on the next clk edge, from any state. FSM goes to IDLE. Period counter and overrun_cnt clear.
- FSM states: IDLE -> CNV -> CONV -> SHIFT -> QUIET -> IDLE.
- Trigger source, sampled every cycle:
  - ext_trig_sel=1: trigger is timetrig high while its registered copy was low (rising edge).
  - ext_trig_sel=0: period counter runs freely while enable=1. It asserts trigger when count == period-1, then reloads 0. It holds at 0 when enable=0 or period=0.
- Trigger handling:
  - Trigger in IDLE with enable=1 is accepted at edge T.
  - Trigger while busy=1 is dropped and overrun_cnt increments; it saturates at all-ones.
  - Trigger with enable=0 is ignored and not counted.
- Accept at T: busy=1 and cnv=1 from T+1.
  - The control word ctrl_words[8*chan_idx +: 8] is latched at T.
  - Later ctrl_words or num_ch changes do not affect the running frame.
- CNV: cnv high for exactly CNV_HIGH_CYCLES cycles.
- CONV: cnv low, scki low for CONV_CYCLES cycles.
- SHIFT: scki starts low and toggles every SCK_HALF cycles, giving exactly N_SCK rising and N_SCK falling edges. Frame ends with scki low.
- sdi:
  - Bit 7 of the latched word is valid on SHIFT entry.
  - Each scki falling edge advances to the next lower bit.
  - After bit 0's period, sdi=0 for the remaining scki periods. sdi=0 outside SHIFT.
- QUIET: QUIET_CYCLES cycles with all pins low.
  - frame_done pulses on the last QUIET cycle.
  - busy drops on the following edge, which is the same edge the FSM re-enters IDLE.
- Frame length with defaults: 4 + 50 + 12*2*2 + 4 = 106 cycles of busy.
  - Earliest next accept is the cycle busy=0.
  - period < 106 therefore yields overruns.
- Channel sequence:
  - chan_idx increments at frame_done and wraps from (effective num_ch - 1) to 0.
  - If the current chan_idx is >= the effective num_ch, the next increment wraps it to 0.
  - chan_idx clears to 0 on reset and on the enable 0->1 edge.
- enable deasserted mid-frame: the current frame completes normally, and no new frame starts.
- Simultaneous trigger and frame_done cycle: the trigger is dropped and counted, because busy=1.

Test Plan:
- Reset, enable=1, ext_trig_sel=1, one timetrig pulse at cycle 10 -> cnv high cycles 12-15; first scki rise at cycle 12+4+50+2; 12 scki rising edges; frame_done once; busy high exactly 106 cycles; chan_idx 0 -> 1.
- ctrl_words[7:0]=8'hA5, num_ch=1 -> sdi sampled on the 12 scki rising edges reads 1,0,1,0,0,1,0,1,0,0,0,0; chan_idx stays 0.
- ext_trig_sel=0, period=200, num_ch=3, run 10 frames -> frames start exactly 200 cycles apart; chan_idx sequence 0,1,2,0,1,2,...; overrun_cnt=0.
- period=50, 5 frame periods -> frames spaced 150 cycles (every third trigger accepted); overrun_cnt increments on each dropped trigger; no frame truncated.
- Assert reset during SHIFT -> cnv=scki=sdi=busy=0 the next cycle; no frame_done; next trigger produces a full 106-cycle frame from chan_idx 0.
- Drop enable mid-CONV -> the frame completes with 12 scki edges and frame_done; following triggers are ignored and overrun_cnt is unchanged.
